// File: rtl/image_ram_writer.sv
// Raster-order frame loader: turns an 8-bit valid/ready pixel stream with start-of-frame into RAM writes.
// Optional FRAME_CHECKSUM_EN keeps a 16-bit wrap-around sum of each frame's written pixels.
module image_ram_writer #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_hold,
    input  logic [7:0]        i_pix_data,
    input  logic              i_pix_valid,
    input  logic              i_pix_sof,
    output logic              o_pix_ready,
    output logic [15:0]       o_wr_address,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_wren,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_sof_err,
    output logic [15:0]       o_checksum,
    output logic [1:0]        o_dbg_state
);

    // Handshake: a pixel is taken on a rising edge where i_pix_valid and o_pix_ready are both high;
    // o_pix_ready depends only on state, i_hold and i_reset, never on i_pix_valid.

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_SOF = 2'd1,
        S_LOAD     = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  w_col_next;
    logic [ROW_W-1:0]  w_row_next;
    logic              w_accept;
    logic              w_write;
    logic              w_frame_start;
    logic              w_sof_err;
    logic [15:0]       w_row_base;
    logic [15:0]       w_wr_addr;

    logic              r_wren;
    logic [15:0]       r_wr_address;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_busy;
    logic              r_done;
    logic              r_sof_err;

    // Reset gates ready so an accept coincident with reset is never acknowledged.
    assign o_pix_ready = ((r_state == S_WAIT_SOF) || (r_state == S_LOAD)) & ~i_hold & ~i_reset;
    assign w_accept    = i_pix_valid & o_pix_ready;

    assign w_row_base = 16'(r_row) * 16'(IMG_W);
    assign w_wr_addr  = w_frame_start ? 16'h0000 : (w_row_base + 16'(r_col));

    always_comb begin
        w_state_next  = r_state;
        w_col_next    = r_col;
        w_row_next    = r_row;
        w_write       = 1'b0;
        w_frame_start = 1'b0;
        w_sof_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_WAIT_SOF;
                    w_col_next   = '0;
                    w_row_next   = '0;
                end
            end
            S_WAIT_SOF: begin
                if (w_accept && i_pix_sof) begin
                    w_write       = 1'b1;
                    w_frame_start = 1'b1;
                    w_col_next    = COL_W'(1);
                    w_row_next    = '0;
                    w_state_next  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    w_write = 1'b1;
                    if (i_pix_sof) begin
                        // Resync: the marked pixel restarts the frame at address 0.
                        w_frame_start = 1'b1;
                        w_sof_err     = 1'b1;
                        w_col_next    = COL_W'(1);
                        w_row_next    = '0;
                    end else if (r_col == COL_LAST) begin
                        w_col_next = '0;
                        if (r_row == ROW_LAST) begin
                            w_row_next   = '0;
                            w_state_next = S_DONE;
                        end else begin
                            w_row_next = r_row + ROW_W'(1);
                        end
                    end else begin
                        w_col_next = r_col + COL_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_col        <= '0;
            r_row        <= '0;
            r_wren       <= 1'b0;
            r_wr_address <= '0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sof_err    <= 1'b0;
        end else begin
            r_col     <= w_col_next;
            r_row     <= w_row_next;
            r_wren    <= w_write;
            r_sof_err <= w_sof_err;
            // busy drops on the edge that leaves DONE, the same edge that raises done.
            r_busy    <= (w_state_next != S_IDLE);
            r_done    <= (r_state == S_DONE);
            if (w_write) begin
                r_wr_address <= w_wr_addr;
                r_wr_data    <= DATA_W'(i_pix_data);
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [15:0] r_sum;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sum <= '0;
        end else if (w_frame_start) begin
            r_sum <= {8'h00, i_pix_data};
        end else if (w_write) begin
            r_sum <= r_sum + {8'h00, i_pix_data};
        end
    end

    assign o_checksum = r_sum;
`else
    assign o_checksum = 16'h0000;
`endif

    assign o_wr_address = r_wr_address;
    assign o_wr_data    = r_wr_data;
    assign o_wren       = r_wren;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_sof_err    = r_sof_err;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_image_ram_writer.sv
// Bench for image_ram_writer: a full 256x256 frame on the default build plus a 4x2 instance
// driven by a per-cycle vector table and hand-written resync / reset-abort sequences.
module tb_image_ram_writer;

  logic clk = 1'b0;
  logic reset, start_b, start_s, hold, pix_valid, pix_sof;
  logic [7:0] pix_data;

  logic        b_ready, b_wren, b_busy, b_done, b_serr;
  logic [15:0] b_addr, b_ck;
  logic [31:0] b_data;
  logic [1:0]  b_state;

  logic        s_ready, s_wren, s_busy, s_done, s_serr;
  logic [15:0] s_addr, s_ck;
  logic [31:0] s_data;
  logic [1:0]  s_state;

  int tests = 0;
  int fails = 0;

  // clock / reset block
  always #5 clk = ~clk;

  image_ram_writer #(.IMG_W(256), .IMG_H(256), .DATA_W(32)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_start(start_b), .i_hold(hold),
    .i_pix_data(pix_data), .i_pix_valid(pix_valid), .i_pix_sof(pix_sof),
    .o_pix_ready(b_ready), .o_wr_address(b_addr), .o_wr_data(b_data), .o_wren(b_wren),
    .o_busy(b_busy), .o_done(b_done), .o_sof_err(b_serr), .o_checksum(b_ck),
    .o_dbg_state(b_state)
  );

  image_ram_writer #(.IMG_W(4), .IMG_H(2), .DATA_W(32)) dut_s (
    .i_clk(clk), .i_reset(reset), .i_start(start_s), .i_hold(hold),
    .i_pix_data(pix_data), .i_pix_valid(pix_valid), .i_pix_sof(pix_sof),
    .o_pix_ready(s_ready), .o_wr_address(s_addr), .o_wr_data(s_data), .o_wren(s_wren),
    .o_busy(s_busy), .o_done(s_done), .o_sof_err(s_serr), .o_checksum(s_ck),
    .o_dbg_state(s_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard for the large instance
  logic [47:0] exp_q[$];
  int          sb_err = 0;
  logic [47:0] sb_first_act = '0;
  logic [47:0] sb_first_exp = '0;
  int          cyc = 0;
  int          b_wren_cnt = 0, b_done_cnt = 0, b_last_wren_cyc = 0, b_done_cyc = 0;
  logic        b_busy_at_done = 1'b1;
  int          s_wren_cnt = 0, s_done_cnt = 0;

  always @(posedge clk) begin
    #3;
    cyc++;
    if (b_wren) begin
      b_wren_cnt++;
      b_last_wren_cyc = cyc;
      if (exp_q.size() == 0) begin
        if (sb_err == 0) begin
          sb_first_act = {b_addr, b_data};
          sb_first_exp = '1;
        end
        sb_err++;
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        if ({b_addr, b_data} !== e) begin
          if (sb_err == 0) begin
            sb_first_act = {b_addr, b_data};
            sb_first_exp = e;
          end
          sb_err++;
        end
      end
    end
    if (b_done) begin
      b_done_cnt++;
      b_done_cyc = cyc;
      b_busy_at_done = b_busy;
    end
    if (s_wren) s_wren_cnt++;
    if (s_done) s_done_cnt++;
  end

  // driver task for the small instance: call at a falling edge, returns at the next one
  logic s_rdy_seen;
  task automatic s_step(input logic rst, input logic st, input logic hd, input logic vl,
                        input logic sf, input logic [7:0] d);
    reset = rst; start_s = st; hold = hd; pix_valid = vl; pix_sof = sf; pix_data = d;
    #1;
    s_rdy_seen = s_ready;
    @(negedge clk);
  endtask

  typedef struct {
    logic       start, hold, valid, sof;
    logic [7:0] data;
    logic       rdy, wren;
    logic [15:0] addr;
    logic [7:0] wdata;
    logic       busy, done, serr;
  } vec_t;

  vec_t vecs[17];

  localparam bit CK_EN =
`ifdef FRAME_CHECKSUM_EN
    1'b1;
`else
    1'b0;
`endif

  initial begin
    int          i, budget, hold_left, hold_bad, d0, w0;
    bit          held;
    logic [15:0] b_sum;

    //           start  hold   valid  sof    data    rdy    wren   addr     wdata   busy   done   serr
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, 16'h0, 8'hAA, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 16'h1, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 1'b1, 1'b1, 16'h2, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 16'h3, 8'h03, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 1'b1, 1'b1, 16'h4, 8'h04, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 1'b1, 1'b1, 16'h5, 8'h05, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h06, 1'b1, 1'b1, 16'h6, 8'h06, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h07, 1'b1, 1'b1, 16'h7, 8'h07, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; start_b = 1'b0; start_s = 1'b0; hold = 1'b0;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", {63'b0, b_ready}, 64'd0);
    check("rst_wren", {63'b0, b_wren}, 64'd0);
    check("rst_addr_data", {16'b0, b_addr, b_data}, 64'd0);
    check("rst_busy_done_serr", {61'b0, b_busy, b_done, b_serr}, 64'd0);
    check("rst_checksum", {48'b0, b_ck}, 64'd0);
    check("rst_small_outs", {59'b0, s_ready, s_wren, s_busy, s_done, s_serr}, 64'd0);
    reset = 1'b0;

    // full 256x256 frame with a 5-cycle hold at pixel 100
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    i = 0; budget = 0; hold_left = 0; hold_bad = 0; held = 1'b0; b_sum = 16'h0;
    while (i < 65536 && budget < 70000) begin
      budget++;
      if (i == 100 && !held) begin
        hold_left = 5;
        held = 1'b1;
      end
      hold = (hold_left > 0);
      pix_valid = 1'b1;
      pix_sof = (i == 0);
      pix_data = i[7:0];
      #1;
      if (hold) begin
        if (b_ready) hold_bad++;
        hold_left--;
      end else if (b_ready) begin
        exp_q.push_back({i[15:0], 24'h0, i[7:0]});
        b_sum = b_sum + {8'h00, i[7:0]};
        i++;
      end
      @(negedge clk);
    end
    pix_valid = 1'b0; pix_sof = 1'b0; hold = 1'b0;
    check("big_all_accepted", 64'(i), 64'd65536);
    check("big_hold_ready_low", 64'(hold_bad), 64'd0);
    repeat (4) @(negedge clk);
    if (sb_err != 0)
      $display("FAIL big_sb_first: got 0x%0h expected 0x%0h", sb_first_act, sb_first_exp);
    check("big_sb_errors", 64'(sb_err), 64'd0);
    check("big_exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("big_wren_count", 64'(b_wren_cnt), 64'd65536);
    check("big_done_count", 64'(b_done_cnt), 64'd1);
    check("big_done_latency", 64'(b_done_cyc), 64'(b_last_wren_cyc + 1));
    check("big_busy_at_done", {63'b0, b_busy_at_done}, 64'd0);
    check("big_last_addr", {48'b0, b_addr}, 64'h0000_0000_0000_FFFF);
    check("big_checksum", {48'b0, b_ck}, CK_EN ? {48'b0, b_sum} : 64'd0);

    // table-driven vectors on the 4x2 instance
    for (int k = 0; k < 17; k++) begin
      s_step(1'b0, vecs[k].start, vecs[k].hold, vecs[k].valid, vecs[k].sof, vecs[k].data);
      check($sformatf("vec%0d_ready", k), {63'b0, s_rdy_seen}, {63'b0, vecs[k].rdy});
      check($sformatf("vec%0d_wren", k), {63'b0, s_wren}, {63'b0, vecs[k].wren});
      if (vecs[k].wren) begin
        check($sformatf("vec%0d_addr", k), {48'b0, s_addr}, {48'b0, vecs[k].addr});
        check($sformatf("vec%0d_data", k), {32'b0, s_data}, {56'b0, vecs[k].wdata});
      end
      check($sformatf("vec%0d_busy", k), {63'b0, s_busy}, {63'b0, vecs[k].busy});
      check($sformatf("vec%0d_done", k), {63'b0, s_done}, {63'b0, vecs[k].done});
      check($sformatf("vec%0d_serr", k), {63'b0, s_serr}, {63'b0, vecs[k].serr});
    end

    // resync: sof arrives at the fourth pixel of a frame
    d0 = s_done_cnt;
    s_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      s_step(1'b0, 1'b0, 1'b0, 1'b1, (k == 0), 8'h10 + 8'(k));
      check($sformatf("resync_pre%0d_addr", k), {47'b0, s_wren, s_addr}, {47'b0, 1'b1, 16'(k)});
    end
    s_step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h20);
    check("resync_sof_wren_serr", {62'b0, s_wren, s_serr}, 64'd3);
    check("resync_sof_addr_data", {16'b0, s_addr, s_data}, 64'h0000_0000_0000_0020);
    for (int k = 1; k < 8; k++) begin
      s_step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'(k));
      check($sformatf("resync_post%0d", k), {46'b0, s_wren, s_serr, s_addr}, {46'b0, 1'b1, 1'b0, 16'(k)});
    end
    s_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("resync_done", {62'b0, s_done, s_busy}, 64'd2);
    check("resync_done_once", 64'(s_done_cnt - d0), 64'd1);

    // reset mid-frame with a coincident pixel, then a clean frame
    s_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    s_step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h40);
    s_step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h41);
    s_step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h42);
    w0 = s_wren_cnt;
    s_step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h43);
    check("abort_ready_in_reset", {63'b0, s_rdy_seen}, 64'd0);
    check("abort_outs", {61'b0, s_wren, s_busy, s_serr}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      s_step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44);
      check($sformatf("abort_idle%0d_ready", k), {63'b0, s_rdy_seen}, 64'd0);
    end
    check("abort_no_wren", 64'(s_wren_cnt - w0), 64'd0);
    s_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      s_step(1'b0, 1'b0, 1'b0, 1'b1, (k == 0), 8'h80 + 8'(k));
      check($sformatf("abort_frame%0d", k), {15'b0, s_wren, s_addr, s_data},
            {15'b0, 1'b1, 16'(k), 24'h0, 8'h80 + 8'(k)});
    end
    s_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("abort_frame_done", {62'b0, s_done, s_busy}, 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
